param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 3-bit-state sequence-detector FSMs in the sequence_detector family.
- Pattern length, pattern value and overlap mode are elaborate-time parameters.
- Adds an input qualifier, a synchronous clear and a saturating match counter.
- Sits on a serial bitstream, e.g. the output of a deserialiser or stimulus generator, and flags each occurrence of PATTERN.

Parameters:
- PATTERN_LEN, 4, number of bits in the pattern; legal range 2..32.
- PATTERN, 4'b1101, PATTERN_LEN-bit pattern; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detection; 0 = non-overlapping (history restarts after each match).
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of history, fill count and match counter
- i_valid  input  1  qualifies i; bit consumed only when high
- i  input  1  serial data bit
- out  output  1  one-cycle match pulse, registered
- match_count  output  CNT_W  saturating count of matches since reset/clr
- filled  output  1  high when history holds PATTERN_LEN valid bits

Behaviour:
- Interface decided: one clock, clk; reset rst is asynchronous and active-high.
- Reset (rst=1, any time including mid-pattern):
  - hist=0, fill=0, out=0, match_count=0, filled=0.
  - Takes effect immediately, with no clock edge needed.
- State:
  - hist: PATTERN_LEN-bit shift register.
  - fill: counter 0..PATTERN_LEN.
- Accepted bit (i_valid=1, clr=0) at rising edge:
  - hist_n = {hist[PATTERN_LEN-2:0], i}.
  - fill_n = min(fill+1, PATTERN_LEN).
- match = accepted bit AND fill_n==PATTERN_LEN AND hist_n==PATTERN.
- Latency and out:
  - out is registered: out=1 in the cycle after the edge that sampled the completing bit, for exactly one cycle.
  - out=0 on every edge without a match.
- i_valid=0: hist, fill and match_count hold; out drops to 0.
- OVERLAP=1: after a match, fill stays PATTERN_LEN, so suffix bits count toward the next match.
- OVERLAP=0: on a match, fill resets to 0. hist is still shifted but ignored until refilled, so the next match needs PATTERN_LEN fresh bits.
- match_count:
  - Increments by 1 on the same edge that sets out.
  - Saturates at 2^CNT_W-1 and never wraps; out still pulses when saturated.
- clr=1 at an edge:
  - hist=0, fill=0, match_count=0, out=0.
  - Wins over a simultaneous i_valid; that bit is discarded.
- filled = (fill==PATTERN_LEN), a registered-state decode.
- Patterns of all 0s are legal. A zero hist is never a false match because fill gates the compare.
- No combinational path from inputs to outputs.
- i while i_valid=0 is don't-care and may be X without affecting state.

Decomposition:
- Package seq_det_pkg holds:
  - localparam OVERLAP_ON=1, OVERLAP_OFF=0.
  - The fill-counter width function clog2(PATTERN_LEN+1).
  - typedef for the mode.
- Sub-module seq_sat_counter (params W; ports clk, rst, clr, inc, count). Saturating up-counter, instantiated for match_count.
- Shift/compare logic stays in the top module.

Test Plan:
- Reset mid-stream: feed 1,1,0; assert rst asynchronously between edges -> out=0, match_count=0, filled=0 immediately; next bits 1,1,0,1 -> out pulses once, 1 cycle after the 4th bit.
- Overlap: defaults, stream 1101101 with i_valid=1 every cycle -> out pulses after bits 4 and 7, match_count=2.
- Non-overlap: OVERLAP=0, same stream 1101101 -> single pulse after bit 4, match_count=1, filled=0 in the cycle after the match.
- Valid gaps: stream 1,1,0,1 with i_valid=0 cycles (i toggling randomly) between each bit -> exactly one pulse, 1 cycle after the last valid bit; no state change during gaps.
- Clear collision: feed 1,1,0, then clr=1 with i_valid=1, i=1 -> no pulse, match_count=0, fill=0; then 1,1,0,1 -> one pulse.
- Saturation: CNT_W=2, PATTERN_LEN=2, PATTERN=2'b11, OVERLAP=1, six consecutive 1s -> out pulses 5 times; match_count goes 1,2,3 then holds at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Overlap-mode encodings and the fill-counter width helper.
package seq_det_pkg;

    localparam int unsigned OVERLAP_ON  = 1;
    localparam int unsigned OVERLAP_OFF = 0;

    typedef enum logic {
        ModeNonOverlap = 1'b0,
        ModeOverlap    = 1'b1
    } overlap_mode_e;

    // Bits needed to hold a fill count in 0..len inclusive.
    function automatic int unsigned fill_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module seq_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector with configurable length, pattern and overlap mode.
// Registered one-cycle match pulse plus a saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned                   PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]        PATTERN     = 4'b1101,
    parameter int unsigned                   OVERLAP     = 1,
    parameter int unsigned                   CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             i_valid,
    input  logic             i,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             filled
);

    localparam int unsigned   FW   = fill_width(PATTERN_LEN);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);
    localparam overlap_mode_e MODE = (OVERLAP == OVERLAP_ON) ? ModeOverlap : ModeNonOverlap;

    if (PATTERN_LEN < 2 || PATTERN_LEN > 32) begin : g_len_chk
        $error("param_seq_detector: PATTERN_LEN must be in 2..32");
    end
    if (OVERLAP != OVERLAP_ON && OVERLAP != OVERLAP_OFF) begin : g_ovl_chk
        $error("param_seq_detector: OVERLAP must be 0 or 1");
    end

    logic [PATTERN_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   out_q, out_d;
    logic                   match;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        match  = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (i_valid) begin
            hist_d = {hist_q[PATTERN_LEN-2:0], i};
            fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
            // fill gates the compare so an all-zero history never matches early
            if (fill_d == FULL && hist_d == PATTERN) begin
                match = 1'b1;
                if (MODE == ModeNonOverlap) begin
                    fill_d = '0;
                end
            end
        end
        out_d = match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    seq_sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (match),
        .count(match_count)
    );

    assign out    = out_q;
    assign filled = (fill_q == FULL);

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector: three instances (overlap, non-overlap,
// saturating 2-bit counter) driven by directed bit streams.
module tb_param_seq_detector;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] clr_v = 3'b000;
    logic [2:0] val_v = 3'b000;
    logic [2:0] dat_v = 3'b000;

    logic       o0, o1, o2;
    logic       f0, f1, f2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_seq_detector u_dut0 (
        .clk(clk), .rst(rst_v[0]), .clr(clr_v[0]), .i_valid(val_v[0]), .i(dat_v[0]),
        .out(o0), .match_count(c0), .filled(f0)
    );

    param_seq_detector #(
        .OVERLAP(0)
    ) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .clr(clr_v[1]), .i_valid(val_v[1]), .i(dat_v[1]),
        .out(o1), .match_count(c1), .filled(f1)
    );

    param_seq_detector #(
        .PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .clr(clr_v[2]), .i_valid(val_v[2]), .i(dat_v[2]),
        .out(o2), .match_count(c2), .filled(f2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pulse_seen(input int k, input logic o, input int cnt);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        total++;
        if (!have || o !== 1'b1) begin
            bad++;
            $display("FAIL unexpected pulse dut%0d: out=%b at cycle %0d, none expected",
                     k, o, cyc);
        end else begin
            if (e.cyc != cyc || e.cnt != cnt) begin
                bad++;
                $display("FAIL pulse dut%0d: got cycle %0d count %0d expected cycle %0d count %0d",
                         k, cyc, cnt, e.cyc, e.cnt);
            end
        end
    endtask

    // Monitors: any non-zero out is a presented match and must match the scoreboard head.
    always @(negedge clk) if (o0 !== 1'b0) pulse_seen(0, o0, int'(c0));
    always @(negedge clk) if (o1 !== 1'b0) pulse_seen(1, o1, int'(c1));
    always @(negedge clk) if (o2 !== 1'b0) pulse_seen(2, o2, int'(c2));

    // Present one accepted bit at a negedge; pulse => expect out one cycle later.
    task automatic send(input int k, input logic b, input bit pulse, input int cnt);
        val_v[k] = 1'b1;
        dat_v[k] = b;
        if (pulse) push(k, cyc + 1, cnt);
        @(negedge clk);
        val_v[k] = 1'b0;
        dat_v[k] = 1'($urandom);
    endtask

    task automatic idle(input int k, input int n);
        for (int j = 0; j < n; j++) begin
            val_v[k] = 1'b0;
            dat_v[k] = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic clear(input int k, input logic v, input logic b);
        clr_v[k] = 1'b1;
        val_v[k] = v;
        dat_v[k] = b;
        @(negedge clk);
        clr_v[k] = 1'b0;
        val_v[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        chk("reset out", int'(o0), 0);
        chk("reset count", int'(c0), 0);
        chk("reset filled", int'(f0), 0);
        chk("reset count dut2", int'(c2), 0);
        @(negedge clk);
        @(negedge clk);
        rst_v = 3'b000;
        @(negedge clk);

        // dut0: match, then asynchronous reset mid-stream, then a fresh match
        send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
        chk("filled before rst", int'(f0), 1);
        #2 rst_v[0] = 1'b1;
        #1;
        chk("async rst out", int'(o0), 0);
        chk("async rst count", int'(c0), 0);
        chk("async rst filled", int'(f0), 0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
        idle(0, 2);
        chk("count after rst stream", int'(c0), 1);

        // dut0 overlap: 1101101 -> pulses after bits 4 and 7
        clear(0, 1'b0, 1'b0);
        chk("clr count", int'(c0), 0);
        chk("clr filled", int'(f0), 0);
        send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
        send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 2);
        idle(0, 2);
        chk("overlap count", int'(c0), 2);
        chk("overlap filled", int'(f0), 1);

        // dut0 valid gaps: random i while i_valid=0 must not disturb state
        clear(0, 1'b0, 1'b0);
        send(0, 1, 0, 0); idle(0, 3);
        send(0, 1, 0, 0); idle(0, 2);
        chk("gap filled", int'(f0), 0);
        send(0, 0, 0, 0); idle(0, 4);
        send(0, 1, 1, 1); idle(0, 3);
        chk("gap count", int'(c0), 1);

        // dut0 clear collision: clr beats a valid '1' that would complete 1101
        clear(0, 1'b0, 1'b0);
        send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0);
        clear(0, 1'b1, 1'b1);
        idle(0, 1);
        chk("collision count", int'(c0), 0);
        chk("collision filled", int'(f0), 0);
        send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
        idle(0, 2);

        // dut1 non-overlap: 1101101 -> one pulse, fill restarts
        send(1, 1, 0, 0); send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 1);
        chk("nonoverlap filled after match", int'(f1), 0);
        send(1, 1, 0, 0); send(1, 0, 0, 0); send(1, 1, 0, 0);
        idle(1, 2);
        chk("nonoverlap count", int'(c1), 1);
        chk("nonoverlap filled", int'(f1), 0);

        // dut2 saturation: six 1s -> five pulses, count 1,2,3,3,3
        send(2, 1, 0, 0);
        send(2, 1, 1, 1); send(2, 1, 1, 2); send(2, 1, 1, 3);
        send(2, 1, 1, 3); send(2, 1, 1, 3);
        idle(2, 3);
        chk("sat count", int'(c2), 3);
        chk("sat filled", int'(f2), 1);

        idle(0, 2);
        chk("dut0 pulses pending", q0.size(), 0);
        chk("dut1 pulses pending", q1.size(), 0);
        chk("dut2 pulses pending", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
